seq_div_16_bit: RTL and testbench

Multi-cycle 16-bit integer divider, the inverse companion to the 16-bit carry-lookahead add/subtract datapath in the ALU. It takes a dividend and divisor, runs a restoring shift-subtract loop at one quotient bit per clock, and returns quotient and remainder with a start/busy/done handshake. It sits beside the combinational ALU as its long-latency functional unit and supports both signed (two's complement) and unsigned operation.

---
 rtl/seq_div_16_bit.sv | 128 ++++++++++++
 tb/tb_seq_div_16_bit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div_16_bit.sv
// Multi-cycle 16-bit signed/unsigned restoring divider, one quotient bit per clock.
// start/busy/done handshake: start is taken only in IDLE; done pulses for one cycle when results land.
module seq_div_16_bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [16:0] r_q;
    logic [15:0] q_q;
    logic [15:0] d_q;
    logic [3:0]  cnt;
    logic        q_neg;
    logic        r_neg;
    logic        dz_q;
    logic        ovf_q;

    logic        load_op;
    logic        run_step;
    logic        fix_step;

    logic [15:0] a_mag;
    logic [15:0] b_mag;
    logic [17:0] r_sh;
    logic [17:0] t;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (divisor == 16'd0) ? FIX : RUN;
            RUN:     if (cnt == 4'd15) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        load_op  = (state == IDLE) && start;
        run_step = (state == RUN);
        fix_step = (state == FIX);
    end

    // Operand magnitudes; 16'h8000 maps to itself and is then treated as unsigned.
    always_comb begin
        a_mag = (is_signed && dividend[15]) ? (16'd0 - dividend) : dividend;
        b_mag = (is_signed && divisor[15])  ? (16'd0 - divisor)  : divisor;
        r_sh  = {r_q, q_q[15]};
        t     = r_sh - {2'b00, d_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= fix_step;
            if (load_op) begin
                r_q   <= '0;
                // A zero divisor keeps the raw dividend so it can be returned as the remainder.
                q_q   <= (divisor == 16'd0) ? dividend : a_mag;
                d_q   <= b_mag;
                cnt   <= '0;
                q_neg <= is_signed && (dividend[15] ^ divisor[15]);
                r_neg <= is_signed && dividend[15];
                dz_q  <= (divisor == 16'd0);
                ovf_q <= is_signed && (dividend == 16'h8000) && (divisor == 16'hFFFF);
            end else if (run_step) begin
                cnt <= cnt + 4'd1;
                if (!t[17]) begin
                    r_q <= t[16:0];
                    q_q <= {q_q[14:0], 1'b1};
                end else begin
                    r_q <= r_sh[16:0];
                    q_q <= {q_q[14:0], 1'b0};
                end
            end else if (fix_step) begin
                div_by_zero <= dz_q;
                overflow    <= ovf_q;
                if (dz_q) begin
                    quotient  <= 16'hFFFF;
                    remainder <= q_q;
                end else begin
                    quotient  <= q_neg ? (16'd0 - q_q) : q_q;
                    remainder <= r_neg ? (16'd0 - r_q[15:0]) : r_q[15:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_div_16_bit.sv
// Bench for seq_div_16_bit: directed corner cases plus random operations,
// checked against an integer-arithmetic reference through an expected queue.
module tb_seq_div_16_bit;

    localparam int W = 34;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    int           cyc;
    int           n_chk;
    int           n_fail;

    seq_div_16_bit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: plain integer division with truncation toward zero.
    function automatic logic [W-1:0] model(input logic s, input logic [15:0] a, input logic [15:0] b);
        int          ia;
        int          ib;
        int          iq;
        int          ir;
        logic [15:0] q16;
        logic [15:0] r16;
        logic        dz;
        logic        ov;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 16'd0) begin
            q16 = 16'hFFFF;
            r16 = a;
            dz  = 1'b1;
        end else begin
            if (s) begin
                ia = $signed(a);
                ib = $signed(b);
            end else begin
                ia = int'(a);
                ib = int'(b);
            end
            iq = ia / ib;
            ir = ia % ib;
            ov = s && (ia == -32768) && (ib == -1);
            q16 = iq[15:0];
            r16 = ir[15:0];
        end
        return {q16, r16, dz, ov};
    endfunction

    // driver: call at a negedge with the DUT idle; returns 1ns after the start edge
    task automatic drive_start(input logic s, input logic [15:0] a, input logic [15:0] b);
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        exp_q.push_back(model(s, a, b));
        exp_cyc_q.push_back(cyc + ((b == 16'd0) ? 2 : 18));
        @(posedge clk);
        #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = $urandom_range(0, 1);
    endtask

    task automatic issue(input logic s, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        drive_start(s, a, b);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    // issue a new operation in the cycle done is high
    task automatic issue_in_done(input logic s, input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done_wait_timeout", done, 1'b1);
        drive_start(s, a, b);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        int           ec;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                chk("quotient",    quotient,    e[33:18]);
                chk("remainder",   remainder,   e[17:2]);
                chk("div_by_zero", div_by_zero, e[1]);
                chk("overflow",    overflow,    e[0]);
                chk("latency",     cyc,         ec);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        s;
        logic [15:0] a;
        logic [15:0] b;
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dz", div_by_zero, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1000 / 7 with busy profile
        issue(1'b0, 16'd1000, 16'd7);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            chk("busy_run", busy, 1'b1);
        end
        @(posedge clk);
        #1;
        chk("busy_after_done", busy, 1'b0);
        chk("done_pulse", done, 1'b1);
        @(posedge clk);
        #1;
        chk("done_one_cycle", done, 1'b0);
        wait_drain();

        issue(1'b1, 16'hFFF9, 16'h0002);
        wait_drain();
        issue(1'b1, 16'h0007, 16'hFFFE);
        wait_drain();
        issue(1'b0, 16'h1234, 16'h0000);
        wait_drain();
        issue(1'b0, 16'd50, 16'd5);
        wait_drain();
        issue(1'b1, 16'h8000, 16'hFFFF);
        wait_drain();
        issue(1'b0, 16'hFFFF, 16'h0001);
        wait_drain();
        issue(1'b1, 16'h8000, 16'h0001);
        wait_drain();
        issue(1'b1, 16'hFFFF, 16'h8000);
        wait_drain();

        // stray start mid-run must be ignored
        issue(1'b0, 16'd5000, 16'd33);
        repeat (5) @(posedge clk);
        #1;
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = 16'h4321;
        divisor   = 16'h0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        // back-to-back start in the done cycle
        issue_in_done(1'b1, 16'hFF00, 16'h0013);
        issue_in_done(1'b0, 16'h9999, 16'h0000);
        issue_in_done(1'b0, 16'd77, 16'd9);
        wait_drain();

        // reset in the middle of an operation
        issue(1'b0, 16'd999, 16'd3);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_cyc_q.delete();
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_quotient", quotient, 0);
        chk("midrst_remainder", remainder, 0);
        chk("midrst_dz", div_by_zero, 0);
        chk("midrst_ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        issue(1'b0, 16'd100, 16'd10);
        wait_drain();

        // random operations, some back-to-back
        for (int i = 0; i < 40; i++) begin
            s = $urandom_range(0, 1);
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 16'h0000;
                1:       b = 16'($urandom_range(1, 15));
                2:       b = 16'hFFFF - 16'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 16'h8000;
            if (exp_q.size() != 0 && $urandom_range(0, 1) == 1) begin
                issue_in_done(s, a, b);
            end else begin
                wait_drain();
                issue(s, a, b);
            end
        end
        wait_drain();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
